// File: rtl/decode_pipe.sv
// Integer/load/store decode stage: combinational decode into a registered
// output stage backed by a one-entry skid buffer so fetch ready stays registered.
module decode_pipe #(
    parameter int XLEN = 64
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            flush_i,
    input  logic            inst_valid_i,
    output logic            inst_ready_o,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1val_i,
    input  logic [XLEN-1:0] rs2val_i,
    input  logic            stall_i,
    output logic            valid_o,
    output logic [XLEN-1:0] inpa_o,
    output logic [XLEN-1:0] inpb_o,
    output logic            invB_o,
    output logic            cflag_o,
    output logic            lsh_en_o,
    output logic            rsh_en_o,
    output logic            ltu_en_o,
    output logic            lts_en_o,
    output logic            sum_en_o,
    output logic            and_en_o,
    output logic            xor_en_o,
    output logic [4:0]      rd_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic            we_o,
    output logic            nomem_o,
    output logic            mem_o,
    output logic [XLEN-1:0] dat_o,
    output logic [2:0]      xrs_rwe_o,
    output logic            illegal_o
);
    localparam logic [2:0] XRS_RWE_S8  = 3'b001;
    localparam logic [2:0] XRS_RWE_S16 = 3'b010;
    localparam logic [2:0] XRS_RWE_S32 = 3'b011;
    localparam logic [2:0] XRS_RWE_S64 = 3'b100;
    localparam logic [2:0] XRS_RWE_U8  = 3'b101;
    localparam logic [2:0] XRS_RWE_U16 = 3'b110;
    localparam logic [2:0] XRS_RWE_U32 = 3'b111;
    localparam logic [2:0] XRS_RWE_NAT = (XLEN == 64) ? XRS_RWE_S64 : XRS_RWE_S32;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    typedef struct packed {
        logic [XLEN-1:0] inpa;
        logic [XLEN-1:0] inpb;
        logic [XLEN-1:0] dat;
        logic            invb;
        logic            cflag;
        logic            lsh_en;
        logic            rsh_en;
        logic            ltu_en;
        logic            lts_en;
        logic            sum_en;
        logic            and_en;
        logic            xor_en;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            we;
        logic            nomem;
        logic            mem;
        logic [2:0]      xrs_rwe;
        logic            illegal;
    } dec_t;

    function automatic dec_t nop_img();
        dec_t n;
        n         = '0;
        n.sum_en  = 1'b1;
        n.nomem   = 1'b1;
        n.xrs_rwe = XRS_RWE_NAT;
        return n;
    endfunction

    logic [2:0]      f3;
    logic [XLEN-1:0] imm_i, imm_s, imm_u, opb, shamt;
    logic            reg_op, is_w, sh5_bad, alt, legal;
    dec_t            dec;

    assign f3 = inst_i[14:12];

    always_comb begin
        imm_i   = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
        imm_s   = {{(XLEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
        imm_u   = {{(XLEN-31){inst_i[31]}}, inst_i[30:12], 12'b0};
        reg_op  = (inst_i[6:0] == OPC_OP) || (inst_i[6:0] == OPC_OP_32);
        is_w    = (inst_i[6:0] == OPC_OP_IMM_32) || (inst_i[6:0] == OPC_OP_32);
        opb     = reg_op ? rs2val_i : imm_i;
        // Shift operand is trimmed to the shamt width the datapath honours.
        shamt   = (XLEN == 64 && !is_w) ? {{(XLEN-6){1'b0}}, opb[5:0]}
                                        : {{(XLEN-5){1'b0}}, opb[4:0]};
        sh5_bad = inst_i[25] && (XLEN == 32 || is_w);
        alt     = inst_i[30] && (reg_op || f3 == 3'b101);
        legal   = 1'b0;
        dec     = nop_img();

        case (inst_i[6:0])
            OPC_OP_IMM, OPC_OP_IMM_32, OPC_OP, OPC_OP_32: begin
                if (reg_op)
                    legal = (inst_i[31:25] == 7'h00) ||
                            (inst_i[31:25] == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
                else if (f3 == 3'b001)
                    legal = (inst_i[31:26] == 6'h00) && !sh5_bad;
                else if (f3 == 3'b101)
                    legal = (inst_i[31:26] == 6'h00 || inst_i[31:26] == 6'h10) && !sh5_bad;
                else
                    legal = 1'b1;
                if (is_w && !(XLEN == 64 && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101)))
                    legal = 1'b0;
                dec.inpa    = rs1val_i;
                dec.inpb    = opb;
                dec.sum_en  = 1'b0;
                dec.rd      = inst_i[11:7];
                dec.rs1     = inst_i[19:15];
                dec.rs2     = reg_op ? inst_i[24:20] : 5'd0;
                dec.xrs_rwe = is_w ? XRS_RWE_S32 : XRS_RWE_NAT;
                case (f3)
                    3'b000: begin dec.sum_en = 1'b1; dec.invb = alt; dec.cflag = alt; end
                    3'b001: begin dec.lsh_en = 1'b1; dec.inpb = shamt; end
                    3'b010: begin dec.lts_en = 1'b1; dec.invb = 1'b1; dec.cflag = 1'b1; end
                    3'b011: begin dec.ltu_en = 1'b1; dec.invb = 1'b1; dec.cflag = 1'b1; end
                    3'b100: dec.xor_en = 1'b1;
                    3'b101: begin dec.rsh_en = 1'b1; dec.cflag = alt; dec.inpb = shamt; end
                    3'b110: begin dec.and_en = 1'b1; dec.xor_en = 1'b1; end
                    default: dec.and_en = 1'b1;
                endcase
            end
            OPC_LUI, OPC_AUIPC: begin
                legal    = 1'b1;
                dec.inpa = (inst_i[6:0] == OPC_AUIPC) ? pc_i : '0;
                dec.inpb = imm_u;
                dec.rd   = inst_i[11:7];
            end
            OPC_LOAD: begin
                legal     = (f3 != 3'b111) && !(XLEN == 32 && (f3 == 3'b011 || f3 == 3'b110));
                dec.inpa  = rs1val_i;
                dec.inpb  = imm_i;
                dec.mem   = 1'b1;
                dec.nomem = 1'b0;
                dec.rd    = inst_i[11:7];
                dec.rs1   = inst_i[19:15];
                case (f3)
                    3'b000:  dec.xrs_rwe = XRS_RWE_S8;
                    3'b001:  dec.xrs_rwe = XRS_RWE_S16;
                    3'b010:  dec.xrs_rwe = XRS_RWE_S32;
                    3'b011:  dec.xrs_rwe = XRS_RWE_S64;
                    3'b100:  dec.xrs_rwe = XRS_RWE_U8;
                    3'b101:  dec.xrs_rwe = XRS_RWE_U16;
                    default: dec.xrs_rwe = XRS_RWE_U32;
                endcase
            end
            OPC_STORE: begin
                legal       = !f3[2] && !(XLEN == 32 && f3 == 3'b011);
                dec.inpa    = rs1val_i;
                dec.inpb    = imm_s;
                dec.dat     = rs2val_i;
                dec.we      = 1'b1;
                dec.mem     = 1'b1;
                dec.nomem   = 1'b0;
                dec.rs1     = inst_i[19:15];
                dec.rs2     = inst_i[24:20];
                dec.xrs_rwe = {1'b0, f3[1:0]} + 3'd1;
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            dec         = nop_img();
            dec.illegal = 1'b1;
        end
    end

    dec_t out_d, out_q, skid_d, skid_q;
    logic valid_d, valid_q, skid_full_d, skid_full_q, accept;

    always_comb begin
        accept      = inst_valid_i && !skid_full_q;
        out_d       = out_q;
        valid_d     = valid_q;
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
        if (flush_i) begin
            out_d       = nop_img();
            valid_d     = 1'b0;
            skid_full_d = 1'b0;
        end else if (!valid_q || !stall_i) begin
            if (skid_full_q) begin
                out_d       = skid_q;
                valid_d     = 1'b1;
                skid_full_d = 1'b0;
            end else if (accept) begin
                out_d   = dec;
                valid_d = 1'b1;
            end else begin
                out_d   = nop_img();
                valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d      = dec;
            skid_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            out_q       <= nop_img();
            valid_q     <= 1'b0;
            skid_full_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            valid_q     <= valid_d;
            skid_full_q <= skid_full_d;
        end
    end

    // Skid contents are only observed while skid_full_q is set.
    always_ff @(posedge clk_i) begin
        skid_q <= skid_d;
    end

    assign inst_ready_o = !skid_full_q;
    assign valid_o      = valid_q;
    assign inpa_o       = out_q.inpa;
    assign inpb_o       = out_q.inpb;
    assign dat_o        = out_q.dat;
    assign invB_o       = out_q.invb;
    assign cflag_o      = out_q.cflag;
    assign lsh_en_o     = out_q.lsh_en;
    assign rsh_en_o     = out_q.rsh_en;
    assign ltu_en_o     = out_q.ltu_en;
    assign lts_en_o     = out_q.lts_en;
    assign sum_en_o     = out_q.sum_en;
    assign and_en_o     = out_q.and_en;
    assign xor_en_o     = out_q.xor_en;
    assign rd_o         = out_q.rd;
    assign rs1_o        = out_q.rs1;
    assign rs2_o        = out_q.rs2;
    assign we_o         = out_q.we;
    assign nomem_o      = out_q.nomem;
    assign mem_o        = out_q.mem;
    assign xrs_rwe_o    = out_q.xrs_rwe;
    assign illegal_o    = out_q.illegal;

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: XLEN=64 and XLEN=32 instances, directed handshake
// scenarios plus random traffic scored against a mnemonic-level decode model.
module tb_decode_pipe;
    localparam logic [2:0] S32 = 3'd3;
    localparam logic [2:0] S64 = 3'd4;

    typedef struct packed {
        logic [63:0] inpa;
        logic [63:0] inpb;
        logic [63:0] dat;
        logic        invb, cflag, lsh, rsh, ltu, lts, sum, a_en, x_en;
        logic [4:0]  rd, rs1, rs2;
        logic        we, nomem, mem;
        logic [2:0]  xrs;
        logic        illegal;
    } exp_t;

    typedef enum {M_ILL, M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_SRA,
                  M_OR, M_AND, M_LUI, M_AUIPC, M_LOAD, M_STORE} mn_t;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, stall = 1'b0, vin = 1'b0, sel32 = 1'b0;
    logic [31:0] inst = '0;
    logic [63:0] pc = '0, rs1 = '0, rs2 = '0;
    logic        v64, v32;
    int          n_cmp = 0, n_bad = 0;
    exp_t        q64[$], q32[$];

    assign v64 = vin & ~sel32;
    assign v32 = vin & sel32;

    always #5 clk = ~clk;

    logic        rdy64, val64, invb64, cf64, lsh64, rsh64, ltu64, lts64, sum64, and64, xor64;
    logic        we64, nomem64, mem64, ill64;
    logic [63:0] inpa64, inpb64, dat64;
    logic [4:0]  rd64, rs1o64, rs2o64;
    logic [2:0]  xrs64;
    logic        rdy32, val32, invb32, cf32, lsh32, rsh32, ltu32, lts32, sum32, and32, xor32;
    logic        we32, nomem32, mem32, ill32;
    logic [31:0] inpa32, inpb32, dat32;
    logic [4:0]  rd32, rs1o32, rs2o32;
    logic [2:0]  xrs32;
    exp_t        a64, a32;

    assign a64 = {inpa64, inpb64, dat64, invb64, cf64, lsh64, rsh64, ltu64, lts64, sum64,
                  and64, xor64, rd64, rs1o64, rs2o64, we64, nomem64, mem64, xrs64, ill64};
    assign a32 = {32'b0, inpa32, 32'b0, inpb32, 32'b0, dat32, invb32, cf32, lsh32, rsh32,
                  ltu32, lts32, sum32, and32, xor32, rd32, rs1o32, rs2o32, we32, nomem32,
                  mem32, xrs32, ill32};

    decode_pipe #(.XLEN(64)) dut64 (
        .clk_i(clk), .reset_i(rst_n), .flush_i(flush), .inst_valid_i(v64), .inst_ready_o(rdy64),
        .inst_i(inst), .pc_i(pc), .rs1val_i(rs1), .rs2val_i(rs2), .stall_i(stall),
        .valid_o(val64), .inpa_o(inpa64), .inpb_o(inpb64), .invB_o(invb64), .cflag_o(cf64),
        .lsh_en_o(lsh64), .rsh_en_o(rsh64), .ltu_en_o(ltu64), .lts_en_o(lts64),
        .sum_en_o(sum64), .and_en_o(and64), .xor_en_o(xor64), .rd_o(rd64), .rs1_o(rs1o64),
        .rs2_o(rs2o64), .we_o(we64), .nomem_o(nomem64), .mem_o(mem64), .dat_o(dat64),
        .xrs_rwe_o(xrs64), .illegal_o(ill64)
    );

    decode_pipe #(.XLEN(32)) dut32 (
        .clk_i(clk), .reset_i(rst_n), .flush_i(flush), .inst_valid_i(v32), .inst_ready_o(rdy32),
        .inst_i(inst), .pc_i(pc[31:0]), .rs1val_i(rs1[31:0]), .rs2val_i(rs2[31:0]),
        .stall_i(stall), .valid_o(val32), .inpa_o(inpa32), .inpb_o(inpb32), .invB_o(invb32),
        .cflag_o(cf32), .lsh_en_o(lsh32), .rsh_en_o(rsh32), .ltu_en_o(ltu32), .lts_en_o(lts32),
        .sum_en_o(sum32), .and_en_o(and32), .xor_en_o(xor32), .rd_o(rd32), .rs1_o(rs1o32),
        .rs2_o(rs2o32), .we_o(we32), .nomem_o(nomem32), .mem_o(mem32), .dat_o(dat32),
        .xrs_rwe_o(xrs32), .illegal_o(ill32)
    );

    function automatic exp_t nop(input int xl);
        exp_t e;
        e       = '0;
        e.sum   = 1'b1;
        e.nomem = 1'b1;
        e.xrs   = (xl == 64) ? S64 : S32;
        return e;
    endfunction

    // Classify the word into a mnemonic first, then derive controls from the mnemonic.
    function automatic exp_t model(input int xl, input logic [31:0] in, input logic [63:0] pcv,
                                   input logic [63:0] a, input logic [63:0] b);
        exp_t        e;
        mn_t         mn;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [63:0] immi, imms, immu, src;
        bit          w, rg, ok;
        int          sh;
        f7   = in[31:25];
        f3   = in[14:12];
        immi = {{52{in[31]}}, in[31:20]};
        imms = {{52{in[31]}}, in[31:25], in[11:7]};
        immu = {{32{in[31]}}, in[31:12], 12'h000};
        e    = nop(xl);
        mn   = M_ILL;
        w    = (in[6:0] == 7'h1b || in[6:0] == 7'h3b);
        rg   = (in[6:0] == 7'h33 || in[6:0] == 7'h3b);
        ok   = 0;
        case (in[6:0])
            7'h13, 7'h33, 7'h1b, 7'h3b: begin
                if (w && xl != 64) ok = 0;
                else if (w && !(f3 == 0 || f3 == 1 || f3 == 5)) ok = 0;
                else if (rg) ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                else if (f3 == 1) ok = (in[31:26] == 0) && !(in[25] && (xl == 32 || w));
                else if (f3 == 5) ok = (in[31:26] == 0 || in[31:26] == 6'h10) && !(in[25] && (xl == 32 || w));
                else ok = 1;
                if (ok) begin
                    case (f3)
                        0: mn = (rg && in[30]) ? M_SUB : M_ADD;
                        1: mn = M_SLL;
                        2: mn = M_SLT;
                        3: mn = M_SLTU;
                        4: mn = M_XOR;
                        5: mn = in[30] ? M_SRA : M_SRL;
                        6: mn = M_OR;
                        default: mn = M_AND;
                    endcase
                end
            end
            7'h37: mn = M_LUI;
            7'h17: mn = M_AUIPC;
            7'h03: if (f3 != 7 && !(xl == 32 && (f3 == 3 || f3 == 6))) mn = M_LOAD;
            7'h23: if (f3 < 4 && !(xl == 32 && f3 == 3)) mn = M_STORE;
            default: mn = M_ILL;
        endcase
        src = rg ? b : immi;
        sh  = (xl == 64 && !w) ? 6 : 5;
        case (mn)
            M_ILL: e.illegal = 1'b1;
            M_LUI, M_AUIPC: begin
                e.inpa = (mn == M_AUIPC) ? pcv : 64'd0;
                e.inpb = immu;
                e.rd   = in[11:7];
            end
            M_LOAD: begin
                e.inpa = a; e.inpb = immi; e.mem = 1; e.nomem = 0;
                e.rd = in[11:7]; e.rs1 = in[19:15]; e.xrs = f3 + 3'd1;
            end
            M_STORE: begin
                e.inpa = a; e.inpb = imms; e.dat = b; e.we = 1; e.mem = 1; e.nomem = 0;
                e.rs1 = in[19:15]; e.rs2 = in[24:20]; e.xrs = f3 + 3'd1;
            end
            default: begin
                e.inpa = a;
                e.inpb = src;
                e.rd   = in[11:7];
                e.rs1  = in[19:15];
                e.rs2  = rg ? in[24:20] : 5'd0;
                e.xrs  = w ? S32 : ((xl == 64) ? S64 : S32);
                e.sum  = 0;
                case (mn)
                    M_ADD:  e.sum = 1;
                    M_SUB:  begin e.sum = 1; e.invb = 1; e.cflag = 1; end
                    M_SLT:  begin e.lts = 1; e.invb = 1; e.cflag = 1; end
                    M_SLTU: begin e.ltu = 1; e.invb = 1; e.cflag = 1; end
                    M_XOR:  e.x_en = 1;
                    M_OR:   begin e.a_en = 1; e.x_en = 1; end
                    M_AND:  e.a_en = 1;
                    M_SLL:  begin e.lsh = 1; e.inpb = src & ((64'd1 << sh) - 1); end
                    M_SRL:  begin e.rsh = 1; e.inpb = src & ((64'd1 << sh) - 1); end
                    default: begin e.rsh = 1; e.cflag = 1; e.inpb = src & ((64'd1 << sh) - 1); end
                endcase
            end
        endcase
        if (xl == 32) begin
            e.inpa = e.inpa & 64'hFFFF_FFFF;
            e.inpb = e.inpb & 64'hFFFF_FFFF;
            e.dat  = e.dat & 64'hFFFF_FFFF;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard producer: record what each accepted beat must decode to.
    always @(posedge clk) begin
        if (!rst_n || flush) begin
            q64.delete();
            q32.delete();
        end else begin
            if (v64 && rdy64) q64.push_back(model(64, inst, pc, rs1, rs2));
            if (v32 && rdy32)
                q32.push_back(model(32, inst, {32'b0, pc[31:0]}, {32'b0, rs1[31:0]}, {32'b0, rs2[31:0]}));
        end
    end

    // Monitors: an output is consumed when valid and not stalled or flushed.
    always @(negedge clk) begin
        if (rst_n && !flush && !stall) begin
            if (val64) begin
                if (q64.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL out64_unexpected: got valid output %0h expected none", a64);
                end else chk("out64", a64, q64.pop_front());
            end
            if (val32) begin
                if (q32.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL out32_unexpected: got valid output %0h expected none", a32);
                end else chk("out32", a32, q32.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b);
        vin  = 1'b1;
        inst = i;
        rs1  = a;
        rs2  = b;
        pc   = {$urandom, $urandom};
    endtask

    task automatic rand_beat();
        logic [31:0] i;
        i = $urandom;
        case ($urandom_range(0, 9))
            0, 8: i[6:0] = 7'h13;
            1: i[6:0] = 7'h33;
            2: i[6:0] = 7'h1b;
            3: i[6:0] = 7'h3b;
            4: i[6:0] = 7'h37;
            5: i[6:0] = 7'h17;
            6: i[6:0] = 7'h03;
            7: i[6:0] = 7'h23;
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0: i[31:25] = 7'h00;
            1: i[31:25] = 7'h20;
            2: i[31:26] = 6'h00;
            default: ;
        endcase
        beat(i, {$urandom, $urandom}, {$urandom, $urandom});
        vin = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        chk("rst64_img", a64, nop(64));
        chk("rst64_valid", val64, 1'b0);
        chk("rst64_ready", rdy64, 1'b1);
        chk("rst32_img", a32, nop(32));
        chk("rst32_valid", val32, 1'b0);
        rst_n = 1'b1;
        tick();

        beat(32'hFFF08293, 64'd5, 64'd0);
        tick(); vin = 1'b0;
        chk("addi_valid", val64, 1'b1);
        chk("addi_inpa", a64.inpa, 64'd5);
        chk("addi_inpb", a64.inpb, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_sum", a64.sum, 1'b1);
        chk("addi_rd", a64.rd, 5'd5);
        chk("addi_nomem", a64.nomem, 1'b1);
        chk("addi_xrs", a64.xrs, S64);

        beat(32'h0021A423, 64'h100, 64'hAB);
        tick(); vin = 1'b0;
        chk("sw_inpa", a64.inpa, 64'h100);
        chk("sw_inpb", a64.inpb, 64'd8);
        chk("sw_dat", a64.dat, 64'hAB);
        chk("sw_we_mem", {a64.we, a64.mem, a64.nomem}, 3'b110);
        chk("sw_rd", a64.rd, 5'd0);
        chk("sw_xrs", a64.xrs, S32);
        tick();

        stall = 1'b1;
        beat(32'h00110393, 64'h11, 64'h0);
        tick();
        chk("skid_a_valid", val64, 1'b1);
        chk("skid_a_ready", rdy64, 1'b1);
        beat(32'h0551C493, 64'h22, 64'h0);
        tick(); vin = 1'b0;
        chk("skid_ready", rdy64, 1'b0);
        chk("skid_hold_rd", a64.rd, 5'd7);
        tick();
        chk("skid_hold2_rd", a64.rd, 5'd7);
        chk("skid_hold2_inpa", a64.inpa, 64'h11);
        stall = 1'b0;
        tick();
        chk("skid_b_valid", val64, 1'b1);
        chk("skid_b_rd", a64.rd, 5'd9);
        tick();
        chk("skid_drain_valid", val64, 1'b0);
        chk("skid_drain_ready", rdy64, 1'b1);

        stall = 1'b1;
        beat(32'h00110393, 64'h33, 64'h0);
        tick();
        beat(32'h0551C493, 64'h44, 64'h0);
        tick();
        chk("flush_pre_ready", rdy64, 1'b0);
        flush = 1'b1;
        beat(32'h00300593, 64'h55, 64'h0);
        tick(); flush = 1'b0; vin = 1'b0;
        chk("flush_valid", val64, 1'b0);
        chk("flush_ready", rdy64, 1'b1);
        chk("flush_img", a64, nop(64));
        flush = 1'b1;
        beat(32'h00300593, 64'h66, 64'h0);
        tick(); flush = 1'b0; vin = 1'b0;
        chk("flush_drop_valid", val64, 1'b0);
        tick();
        chk("flush_drop_valid2", val64, 1'b0);

        beat(32'h00110393, 64'h77, 64'h0);
        tick(); vin = 1'b0;
        chk("arst_pre_valid", val64, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", val64, 1'b0);
        chk("arst_img", a64, nop(64));
        tick();
        rst_n = 1'b1;
        stall = 1'b0;
        tick();
        chk("arst_ready", rdy64, 1'b1);
        chk("arst_valid_after", val64, 1'b0);

        sel32 = 1'b1;
        beat(32'h0000B003, 64'h10, 64'h0);
        tick(); vin = 1'b0;
        chk("ld32_valid", val32, 1'b1);
        chk("ld32_illegal", a32.illegal, 1'b1);
        chk("ld32_nomem", a32.nomem, 1'b1);
        beat(32'h02009093, 64'h10, 64'h0);
        tick(); vin = 1'b0;
        chk("slli32_illegal", a32.illegal, 1'b1);
        beat(32'h01F09093, 64'h10, 64'h0);
        tick(); vin = 1'b0;
        chk("slli31_legal", a32.illegal, 1'b0);
        chk("slli31_inpb", a32.inpb, 64'd31);
        tick();

        for (int ph = 0; ph < 2; ph++) begin
            sel32 = ph[0];
            for (int i = 0; i < 600; i++) begin
                rand_beat();
                stall = ($urandom_range(0, 2) == 0);
                flush = ($urandom_range(0, 39) == 0);
                tick();
            end
            vin = 1'b0; stall = 1'b0; flush = 1'b0;
            repeat (4) tick();
        end
        chk("q64_drained", q64.size(), 0);
        chk("q32_drained", q32.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- Parametrised successor to the KCP53K cpu2 decode stage.
- Decodes RV32I/RV64I integer ALU, LUI/AUIPC, load and store instructions into ALU, memory and writeback controls.
- Registered output stage plus one-entry skid buffer, with a valid/ready handshake toward fetch, backpressure from execute, and flush for redirects.
- XLEN selects 32- or 64-bit datapath; W-form and doubleword instructions exist only at XLEN=64.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- flush_i  in  1  discard output register and skid contents.
- inst_valid_i  in  1  instruction beat offered.
- inst_ready_o  out  1  beat accepted when valid&ready.
- inst_i  in  32  instruction word.
- pc_i  in  XLEN  instruction address (AUIPC).
- rs1val_i, rs2val_i  in  XLEN  register file read data, same cycle as inst_i.
- stall_i  in  1  execute cannot take output this cycle.
- valid_o  out  1  output register holds a decoded instruction.
- inpa_o, inpb_o  out  XLEN  ALU operands.
- invB_o, cflag_o  out  1  invert B / carry-in; cflag_o also selects arithmetic right shift.
- lsh_en_o, rsh_en_o, ltu_en_o, lts_en_o, sum_en_o, and_en_o, xor_en_o  out  1  ALU function enables.
- rd_o, rs1_o, rs2_o  out  5  register fields.
- we_o  out  1  memory write (store).
- nomem_o, mem_o  out  1  no memory access / memory access.
- dat_o  out  XLEN  store data.
- xrs_rwe_o  out  3  access size/sign code (xrs.vh).
- illegal_o  out  1  unrecognised or XLEN-illegal encoding.

Behaviour:

Reset (reset_i low, asynchronous), also the bubble/NOP image:
- valid_o=0; skid empty; inst_ready_o=1.
- inpa/inpb/dat=0; all enables 0 except sum_en_o=1; invB=cflag=0.
- rd/rs1/rs2=0; we=0, nomem=1, mem=0, illegal=0.
- xrs_rwe_o = `XRS_RWE_S64 (XLEN=64) or `XRS_RWE_S32 (XLEN=32).

Handshake:
- Latency is one cycle from accept to valid_o.
- inst_ready_o = ~skid_full (registered; never depends on stall_i combinationally).
- Output register loads when ~valid_o or ~stall_i:
  - from skid if skid is full; skid empties.
  - else the decoded accepted beat.
  - else the bubble with valid_o=0.
- When valid_o & stall_i: an accepted beat goes into skid; output holds all fields stable.
- flush_i has priority over everything: next cycle valid_o=0, skid empty, outputs = NOP image; a beat offered that cycle is consumed and dropped.

Decode:
- OP-IMM / OP: inpa=rs1val, inpb=sext(I-imm) or rs2val.
  - SUB: invB=1, cflag=1.
  - SLT/SLTI: invB=1, cflag=1, lts_en. SLTU/SLTIU: invB=1, cflag=1, ltu_en.
  - AND: and_en. XOR: xor_en. OR: and_en & xor_en.
  - SLL: lsh_en. SRL: rsh_en. SRA: rsh_en, cflag=1.
  - Shift amount is 6 bits at XLEN=64, 5 bits at XLEN=32. At XLEN=32, imm[5]=1 is illegal.
  - xrs_rwe is S64 (XLEN=64) or S32 (XLEN=32).
- OP-IMM-32 / OP-32 (XLEN=64 only): as above with xrs_rwe=S32; shamt[5]=1 is illegal.
- LUI: inpa=0, inpb=sext(imm<<12). AUIPC: inpa=pc_i, same inpb.
- LOAD: inpa=rs1val, inpb=sext(I-imm), mem=1, nomem=0.
  - xrs_rwe from funct3: S8/S16/S32/S64/U8/U16/U32.
  - LD and LWU are illegal at XLEN=32.
- STORE: inpa=rs1val, inpb=sext(S-imm), dat=rs2val, we=1, mem=1, nomem=0, rd=0.
  - xrs_rwe is S8/S16/S32/S64; SD is illegal at XLEN=32.
- Any other opcode, or a reserved funct3/funct7: NOP image with illegal_o=1, valid_o=1.

Test Plan:
- Assert reset_i low mid-stream with valid_o=1 -> valid_o=0 and NOP image immediately; inst_ready_o=1 after release.
- XLEN=64, ADDI x5,x1,-1 (0xFFF08293), rs1val=5 -> next cycle: valid_o=1, inpa=5, inpb=0xFFFF_FFFF_FFFF_FFFF, sum_en=1, rd=5, nomem=1, xrs_rwe=S64.
- XLEN=64, SW x2,8(x3) (0x0021A423), rs1val=0x100, rs2val=0xAB -> inpb=8, dat=0xAB, we=1, mem=1, rd=0, xrs_rwe=S32.
- Hold stall_i=1 and present two back-to-back beats -> second beat lands in skid, inst_ready_o=0, outputs unchanged. Release stall -> the two beats emerge in order on consecutive cycles.
- Assert flush_i with output and skid full -> next cycle valid_o=0, inst_ready_o=1; the beat offered during flush never appears.
- XLEN=32, LD (0x0000B003) -> illegal_o=1, valid_o=1, nomem=1. XLEN=32, SLLI with shamt=32 -> illegal_o=1.
